// File: rtl/issue_queue_collapse_if.sv
// Dispatch, CDB and issue bundle for the collapsing issue queue.
// The queue takes the slave side; the dispatch/CDB/unit side is the master.
interface issue_queue_collapse_if #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
);
   logic              dispatch_valid;
   logic              dispatch_ready;
   logic [OP_W-1:0]   dispatch_opcode;
   logic [TAG_W-1:0]  dispatch_rd_tag;
   logic [TAG_W-1:0]  dispatch_rs1_tag;
   logic [TAG_W-1:0]  dispatch_rs2_tag;
   logic [DATA_W-1:0] dispatch_rs1_data;
   logic [DATA_W-1:0] dispatch_rs2_data;
   logic              dispatch_rs1_data_val;
   logic              dispatch_rs2_data_val;
   logic              CDB_valid;
   logic [TAG_W-1:0]  CDB_tag;
   logic [DATA_W-1:0] CDB_data;
   logic              issue_valid;
   logic              issue_ready;
   logic [OP_W-1:0]   issue_opcode;
   logic [TAG_W-1:0]  issue_rd_tag;
   logic [DATA_W-1:0] issue_rs1_data;
   logic [DATA_W-1:0] issue_rs2_data;
   logic              issueque_full;
   logic [CNT_W-1:0]  issueque_count;

   modport master (
      output dispatch_valid, dispatch_opcode, dispatch_rd_tag,
      output dispatch_rs1_tag, dispatch_rs2_tag,
      output dispatch_rs1_data, dispatch_rs2_data,
      output dispatch_rs1_data_val, dispatch_rs2_data_val,
      output CDB_valid, CDB_tag, CDB_data, issue_ready,
      input  dispatch_ready, issue_valid, issue_opcode, issue_rd_tag,
      input  issue_rs1_data, issue_rs2_data,
      input  issueque_full, issueque_count
   );

   modport slave (
      input  dispatch_valid, dispatch_opcode, dispatch_rd_tag,
      input  dispatch_rs1_tag, dispatch_rs2_tag,
      input  dispatch_rs1_data, dispatch_rs2_data,
      input  dispatch_rs1_data_val, dispatch_rs2_data_val,
      input  CDB_valid, CDB_tag, CDB_data, issue_ready,
      output dispatch_ready, issue_valid, issue_opcode, issue_rd_tag,
      output issue_rs1_data, issue_rs2_data,
      output issueque_full, issueque_count
   );
endinterface

// File: rtl/issue_queue_collapse.sv
// Collapsing issue queue: oldest-ready select, CDB operand capture,
// valid/ready issue handshake, flush and occupancy reporting.
module issue_queue_collapse #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   issue_queue_collapse_if.slave bus
);

   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [DEPTH-1:0]  v1_q, v1_d, v2_q, v2_d;
   logic [OP_W-1:0]   op_q [DEPTH];
   logic [OP_W-1:0]   op_d [DEPTH];
   logic [TAG_W-1:0]  rd_q [DEPTH];
   logic [TAG_W-1:0]  rd_d [DEPTH];
   logic [TAG_W-1:0]  t1_q [DEPTH];
   logic [TAG_W-1:0]  t1_d [DEPTH];
   logic [TAG_W-1:0]  t2_q [DEPTH];
   logic [TAG_W-1:0]  t2_d [DEPTH];
   logic [DATA_W-1:0] d1_q [DEPTH];
   logic [DATA_W-1:0] d1_d [DEPTH];
   logic [DATA_W-1:0] d2_q [DEPTH];
   logic [DATA_W-1:0] d2_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   // entries after CDB capture, and the same view shifted down by one
   logic [DEPTH-1:0]  w_v1, w_v2;
   logic [DATA_W-1:0] w_d1 [DEPTH];
   logic [DATA_W-1:0] w_d2 [DEPTH];
   logic [DEPTH-1:0]  up_vld, up_v1, up_v2;
   logic [OP_W-1:0]   up_op [DEPTH];
   logic [TAG_W-1:0]  up_rd [DEPTH];
   logic [TAG_W-1:0]  up_t1 [DEPTH];
   logic [TAG_W-1:0]  up_t2 [DEPTH];
   logic [DATA_W-1:0] up_d1 [DEPTH];
   logic [DATA_W-1:0] up_d2 [DEPTH];

   logic [DEPTH-1:0]  rdy, ge, oh;
   logic              full, iss_fire, disp_fire;
   logic [CNT_W-1:0]  ins_pos;
   logic              byp1, byp2;

   assign rdy  = vld_q & v1_q & v2_q;
   assign full = (count_q == CNT_W'(DEPTH));

   // ge[i]: some entry at index <= i is ready, i.e. i is at/above the pick
   always_comb begin
      logic acc;
      acc = 1'b0;
      ge  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         acc   = acc | rdy[i];
         ge[i] = acc;
      end
   end

   assign oh = rdy & ~(ge << 1);

   always_comb begin
      bus.issue_opcode   = '0;
      bus.issue_rd_tag   = '0;
      bus.issue_rs1_data = '0;
      bus.issue_rs2_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (oh[i]) begin
            bus.issue_opcode   = op_q[i];
            bus.issue_rd_tag   = rd_q[i];
            bus.issue_rs1_data = d1_q[i];
            bus.issue_rs2_data = d2_q[i];
         end
      end
   end

   assign bus.issue_valid    = |rdy;
   assign bus.dispatch_ready = !full;
   assign bus.issueque_full  = full;
   assign bus.issueque_count = count_q;

   assign iss_fire  = (|rdy) & bus.issue_ready & !flush;
   assign disp_fire = bus.dispatch_valid & !full & !flush;
   assign ins_pos   = count_q - CNT_W'(iss_fire);

   assign byp1 = !bus.dispatch_rs1_data_val && bus.CDB_valid &&
                 (bus.dispatch_rs1_tag == bus.CDB_tag);
   assign byp2 = !bus.dispatch_rs2_data_val && bus.CDB_valid &&
                 (bus.dispatch_rs2_tag == bus.CDB_tag);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         logic h1, h2;
         h1 = bus.CDB_valid && !v1_q[i] && (t1_q[i] == bus.CDB_tag);
         h2 = bus.CDB_valid && !v2_q[i] && (t2_q[i] == bus.CDB_tag);
         w_v1[i] = v1_q[i] | h1;
         w_v2[i] = v2_q[i] | h2;
         w_d1[i] = h1 ? bus.CDB_data : d1_q[i];
         w_d2[i] = h2 ? bus.CDB_data : d2_q[i];
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         up_vld[i] = vld_q[i+1];
         up_v1[i]  = w_v1[i+1];
         up_v2[i]  = w_v2[i+1];
         up_op[i]  = op_q[i+1];
         up_rd[i]  = rd_q[i+1];
         up_t1[i]  = t1_q[i+1];
         up_t2[i]  = t2_q[i+1];
         up_d1[i]  = w_d1[i+1];
         up_d2[i]  = w_d2[i+1];
      end
      up_vld[DEPTH-1] = 1'b0;
      up_v1[DEPTH-1]  = w_v1[DEPTH-1];
      up_v2[DEPTH-1]  = w_v2[DEPTH-1];
      up_op[DEPTH-1]  = op_q[DEPTH-1];
      up_rd[DEPTH-1]  = rd_q[DEPTH-1];
      up_t1[DEPTH-1]  = t1_q[DEPTH-1];
      up_t2[DEPTH-1]  = t2_q[DEPTH-1];
      up_d1[DEPTH-1]  = w_d1[DEPTH-1];
      up_d2[DEPTH-1]  = w_d2[DEPTH-1];
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (iss_fire && ge[i]) begin
            vld_d[i] = up_vld[i];
            v1_d[i]  = up_v1[i];
            v2_d[i]  = up_v2[i];
            op_d[i]  = up_op[i];
            rd_d[i]  = up_rd[i];
            t1_d[i]  = up_t1[i];
            t2_d[i]  = up_t2[i];
            d1_d[i]  = up_d1[i];
            d2_d[i]  = up_d2[i];
         end else begin
            vld_d[i] = vld_q[i];
            v1_d[i]  = w_v1[i];
            v2_d[i]  = w_v2[i];
            op_d[i]  = op_q[i];
            rd_d[i]  = rd_q[i];
            t1_d[i]  = t1_q[i];
            t2_d[i]  = t2_q[i];
            d1_d[i]  = w_d1[i];
            d2_d[i]  = w_d2[i];
         end
         if (disp_fire && (CNT_W'(i) == ins_pos)) begin
            vld_d[i] = 1'b1;
            op_d[i]  = bus.dispatch_opcode;
            rd_d[i]  = bus.dispatch_rd_tag;
            t1_d[i]  = bus.dispatch_rs1_tag;
            t2_d[i]  = bus.dispatch_rs2_tag;
            v1_d[i]  = bus.dispatch_rs1_data_val | byp1;
            v2_d[i]  = bus.dispatch_rs2_data_val | byp2;
            d1_d[i]  = byp1 ? bus.CDB_data : bus.dispatch_rs1_data;
            d2_d[i]  = byp2 ? bus.CDB_data : bus.dispatch_rs2_data;
         end
      end
      count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
      if (flush) begin
         vld_d   = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         count_q <= '0;
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
      end
   end

   // payload is meaningless while its valid bit is clear
   always_ff @(posedge clk) begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      op_q <= op_d;
      rd_q <= rd_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
   end

endmodule

// File: tb/tb_issue_queue_collapse.sv
// Bench for issue_queue_collapse: vector table plus an issue scoreboard,
// on a 4-entry and an 8-entry instance.
module tb_issue_queue_collapse;

   logic clk = 1'b0;
   logic rst;
   logic flush4, flush8;

   always #5 clk = ~clk;

   issue_queue_collapse_if #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .OP_W(4)) b4 ();
   issue_queue_collapse_if #(.DEPTH(8), .TAG_W(7), .DATA_W(32), .OP_W(4)) b8 ();

   issue_queue_collapse #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .OP_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush4), .bus(b4)
   );
   issue_queue_collapse #(.DEPTH(8), .TAG_W(7), .DATA_W(32), .OP_W(4)) dut8 (
      .clk(clk), .rst(rst), .flush(flush8), .bus(b8)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [6:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   typedef struct {
      logic       dv;
      logic [5:0] rd;
      logic       rdy_pre;
      logic       ir;
      int         cnt;
      logic       full;
   } vec_t;

   exp_t q4[$];
   exp_t q8[$];
   vec_t tv[8];
   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic idle4();
      b4.dispatch_valid = 0; b4.dispatch_opcode = 0; b4.dispatch_rd_tag = 0;
      b4.dispatch_rs1_tag = 0; b4.dispatch_rs2_tag = 0;
      b4.dispatch_rs1_data = 0; b4.dispatch_rs2_data = 0;
      b4.dispatch_rs1_data_val = 0; b4.dispatch_rs2_data_val = 0;
      b4.CDB_valid = 0; b4.CDB_tag = 0; b4.CDB_data = 0; b4.issue_ready = 0;
   endtask

   task automatic idle8();
      b8.dispatch_valid = 0; b8.dispatch_opcode = 0; b8.dispatch_rd_tag = 0;
      b8.dispatch_rs1_tag = 0; b8.dispatch_rs2_tag = 0;
      b8.dispatch_rs1_data = 0; b8.dispatch_rs2_data = 0;
      b8.dispatch_rs1_data_val = 0; b8.dispatch_rs2_data_val = 0;
      b8.CDB_valid = 0; b8.CDB_tag = 0; b8.CDB_data = 0; b8.issue_ready = 0;
   endtask

   task automatic disp4(input logic [5:0] rd,
                        input logic [5:0] t1, input logic v1, input logic [31:0] a,
                        input logic [5:0] t2, input logic v2, input logic [31:0] b);
      b4.dispatch_valid = 1; b4.dispatch_opcode = rd[3:0]; b4.dispatch_rd_tag = rd;
      b4.dispatch_rs1_tag = t1; b4.dispatch_rs1_data_val = v1; b4.dispatch_rs1_data = a;
      b4.dispatch_rs2_tag = t2; b4.dispatch_rs2_data_val = v2; b4.dispatch_rs2_data = b;
   endtask

   task automatic disp8(input logic [6:0] rd,
                        input logic [6:0] t1, input logic v1, input logic [31:0] a,
                        input logic [6:0] t2, input logic v2, input logic [31:0] b);
      b8.dispatch_valid = 1; b8.dispatch_opcode = rd[3:0]; b8.dispatch_rd_tag = rd;
      b8.dispatch_rs1_tag = t1; b8.dispatch_rs1_data_val = v1; b8.dispatch_rs1_data = a;
      b8.dispatch_rs2_tag = t2; b8.dispatch_rs2_data_val = v2; b8.dispatch_rs2_data = b;
   endtask

   task automatic push4(input logic [5:0] rd, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.op = rd[3:0]; e.rd = {1'b0, rd}; e.a = a; e.b = b;
      q4.push_back(e);
   endtask

   task automatic push8(input logic [6:0] rd, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.op = rd[3:0]; e.rd = rd; e.a = a; e.b = b;
      q8.push_back(e);
   endtask

   task automatic mon();
      exp_t e;
      if (b4.issue_valid && b4.issue_ready && !flush4) begin
         chk("sb4_avail", q4.size() != 0, 1);
         if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("iss4_rd", b4.issue_rd_tag, e.rd);
            chk("iss4_op", b4.issue_opcode, e.op);
            chk("iss4_rs1", b4.issue_rs1_data, e.a);
            chk("iss4_rs2", b4.issue_rs2_data, e.b);
         end
      end
      if (b8.issue_valid && b8.issue_ready && !flush8) begin
         chk("sb8_avail", q8.size() != 0, 1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("iss8_rd", b8.issue_rd_tag, e.rd);
            chk("iss8_op", b8.issue_opcode, e.op);
            chk("iss8_rs1", b8.issue_rs1_data, e.a);
            chk("iss8_rs2", b8.issue_rs2_data, e.b);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tv[0] = '{1'b1, 6'd1, 1'b1, 1'b0, 1, 1'b0};
      tv[1] = '{1'b1, 6'd2, 1'b1, 1'b0, 2, 1'b0};
      tv[2] = '{1'b1, 6'd3, 1'b1, 1'b0, 3, 1'b0};
      tv[3] = '{1'b1, 6'd4, 1'b1, 1'b0, 4, 1'b1};
      tv[4] = '{1'b1, 6'd9, 1'b0, 1'b1, 3, 1'b0};
      tv[5] = '{1'b0, 6'd0, 1'b1, 1'b1, 2, 1'b0};
      tv[6] = '{1'b0, 6'd0, 1'b1, 1'b1, 1, 1'b0};
      tv[7] = '{1'b0, 6'd0, 1'b1, 1'b1, 0, 1'b0};

      rst = 1; flush4 = 0; flush8 = 0;
      idle4(); idle8();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count4", b4.issueque_count, 0);
      chk("rst_full4", b4.issueque_full, 0);
      chk("rst_dready4", b4.dispatch_ready, 1);
      chk("rst_ivalid4", b4.issue_valid, 0);
      chk("rst_ird4", b4.issue_rd_tag, 0);
      chk("rst_irs14", b4.issue_rs1_data, 0);
      chk("rst_count8", b8.issueque_count, 0);
      chk("rst_ivalid8", b8.issue_valid, 0);
      rst = 0;

      // fill, refuse while full, then drain in order
      for (int i = 0; i < 8; i++) begin
         idle4();
         if (tv[i].dv)
            disp4(tv[i].rd, 6'd0, 1'b1, 32'h100 + i, 6'd0, 1'b1, 32'h200 + i);
         b4.issue_ready = tv[i].ir;
         if (tv[i].dv && tv[i].rdy_pre)
            push4(tv[i].rd, 32'h100 + i, 32'h200 + i);
         @(negedge clk);
         chk("v_dready", b4.dispatch_ready, tv[i].rdy_pre);
         mon();
         @(posedge clk);
         #1;
         chk("v_count", b4.issueque_count, tv[i].cnt);
         chk("v_full", b4.issueque_full, tv[i].full);
      end

      // younger ready entry bypasses older waiting one
      idle4(); b4.issue_ready = 1;
      disp4(6'd10, 6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h22);
      step();
      idle4(); b4.issue_ready = 1;
      disp4(6'd11, 6'd0, 1'b1, 32'h31, 6'd0, 1'b1, 32'h32);
      push4(6'd11, 32'h31, 32'h32);
      step();
      idle4(); b4.issue_ready = 1;
      b4.CDB_valid = 1; b4.CDB_tag = 6'd5; b4.CDB_data = 32'hDEADBEEF;
      push4(6'd10, 32'hDEADBEEF, 32'h22);
      step();
      chk("t2_wake_ivalid", b4.issue_valid, 1);
      idle4(); b4.issue_ready = 1;
      step();
      chk("t2_count", b4.issueque_count, 0);

      // dispatch-time CDB bypass
      idle4();
      disp4(6'd12, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h77);
      b4.CDB_valid = 1; b4.CDB_tag = 6'd9; b4.CDB_data = 32'h1234;
      step();
      chk("t3_ivalid", b4.issue_valid, 1);
      chk("t3_rs1", b4.issue_rs1_data, 32'h1234);
      idle4(); b4.issue_ready = 1;
      push4(6'd12, 32'h1234, 32'h77);
      step();
      chk("t3_count", b4.issueque_count, 0);

      // full: issue head, wake tail, refused dispatch, all in one cycle
      for (int i = 0; i < 4; i++) begin
         idle4();
         if (i < 3) begin
            disp4(6'h10 + 6'(i), 6'd0, 1'b1, 32'h10 + i, 6'd0, 1'b1, 32'h20 + i);
            push4(6'h10 + 6'(i), 32'h10 + i, 32'h20 + i);
         end else begin
            disp4(6'h13, 6'd0, 1'b1, 32'h13, 6'h21, 1'b0, 32'h0);
            push4(6'h13, 32'h13, 32'hCAFE);
         end
         step();
      end
      idle4(); b4.issue_ready = 1;
      b4.CDB_valid = 1; b4.CDB_tag = 6'h21; b4.CDB_data = 32'hCAFE;
      disp4(6'h3F, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
      @(negedge clk);
      chk("t4_dready_full", b4.dispatch_ready, 0);
      mon();
      @(posedge clk);
      #1;
      chk("t4_count", b4.issueque_count, 3);
      chk("t4_dready_after", b4.dispatch_ready, 1);
      chk("t4_head", b4.issue_rd_tag, 6'h11);
      idle4(); b4.issue_ready = 1;
      repeat (3) step();
      chk("t4_drained", b4.issueque_count, 0);
      chk("t4_ivalid", b4.issue_valid, 0);

      // flush discards queued entries and same-cycle handshakes
      for (int i = 0; i < 3; i++) begin
         idle4();
         disp4(6'h20 + 6'(i), 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 32'h6);
         step();
      end
      chk("t5_count_pre", b4.issueque_count, 3);
      idle4(); b4.issue_ready = 1;
      disp4(6'h30, 6'd0, 1'b1, 32'h7, 6'd0, 1'b1, 32'h8);
      flush4 = 1;
      step();
      flush4 = 0;
      idle4();
      chk("t5_count", b4.issueque_count, 0);
      chk("t5_ivalid", b4.issue_valid, 0);
      chk("t5_dready", b4.dispatch_ready, 1);
      step();
      chk("t5_count_post", b4.issueque_count, 0);

      // 8-deep: fill with waiting entries, wake youngest first
      for (int i = 0; i < 8; i++) begin
         idle8();
         disp8(7'h50 + 7'(i), 7'h40 + 7'(i), 1'b0, 32'h0, 7'd0, 1'b1, 32'(i));
         step();
      end
      chk("t6_count", b8.issueque_count, 8);
      chk("t6_full", b8.issueque_full, 1);
      chk("t6_ivalid", b8.issue_valid, 0);
      for (int k = 0; k < 8; k++) begin
         idle8(); b8.issue_ready = 1;
         b8.CDB_valid = 1; b8.CDB_tag = 7'h47 - 7'(k); b8.CDB_data = 32'hA0 + 7 - k;
         push8(7'h57 - 7'(k), 32'hA0 + 7 - k, 32'(7 - k));
         step();
      end
      idle8(); b8.issue_ready = 1;
      step();
      chk("t6_count_end", b8.issueque_count, 0);
      chk("t6_full_end", b8.issueque_full, 0);

      chk("sb4_left", q4.size(), 0);
      chk("sb8_left", q8.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
